// File: rtl/magnetron_duty_ctrl_pkg.sv
// Shared definitions for the magnetron duty-cycle controller: state encodings
// (identical to the panel/display encodings) and a sizing helper.
package magnetron_duty_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COOK  = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  // Counter width for a range 0..n-1, never narrower than one bit.
  function automatic int unsigned bits_for(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/magnetron_duty_ctrl_duty_gen.sv
// Time-proportional duty generator: a LEVELS*SLICE-cycle window counter, a
// power-level latch refreshed at window start, and the registered on/off compare.
module mag_duty_gen
  import magnetron_duty_ctrl_pkg::*;
#(
  parameter int unsigned LEVELS = 10,
  parameter int unsigned SLICE  = 100,
  localparam int unsigned PW    = $clog2(LEVELS + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          run,
  input  logic          restart,
  input  logic [PW-1:0] power_level,
  output logic          duty
);

  localparam int unsigned WIN   = LEVELS * SLICE;
  localparam int unsigned WW    = bits_for(WIN);
  localparam int unsigned PRODW = $clog2(WIN + 1);

  logic [WW-1:0] win;
  logic [WW-1:0] win_next;
  logic [PW-1:0] lvl;
  logic [PW-1:0] lvl_next;
  logic [PW-1:0] lvl_clamp;
  logic          wrap;
  logic          duty_q;
  logic          duty_next;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; a missing default is how a latch gets inferred.
  always_comb begin
    win_next  = '0;
    lvl_next  = lvl;
    wrap      = (win == WW'(WIN - 1));
    lvl_clamp = (power_level > PW'(LEVELS)) ? PW'(LEVELS) : power_level;

    if (run) begin
      if (restart || wrap) begin
        win_next = '0;
        lvl_next = lvl_clamp;
      end else begin
        win_next = win + WW'(1);
      end
    end

    // lvl*SLICE never exceeds WIN, so PRODW bits hold the threshold exactly.
    duty_next = run && (PRODW'(win_next) < (PRODW'(lvl_next) * PRODW'(SLICE)));
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      win    <= '0;
      lvl    <= '0;
      duty_q <= 1'b0;
    end else begin
      win    <= win_next;
      lvl    <= lvl_next;
      duty_q <= duty_next;
    end
  end

  assign duty = duty_q;

endmodule

// File: rtl/magnetron_duty_ctrl.sv
// Magnetron cook/pause/idle controller with duty-cycled power and a hard door
// interlock. Optional post-cook start lockout enabled by `define MAG_COOLDOWN_EN.
module magnetron_duty_ctrl
  import magnetron_duty_ctrl_pkg::*;
#(
  parameter int unsigned LEVELS      = 10,
  parameter int unsigned SLICE       = 100,
  parameter int unsigned COOL_CYCLES = 1000,
  localparam int unsigned PW         = $clog2(LEVELS + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          startn,
  input  logic          stopn,
  input  logic          clearn,
  input  logic          door_closed,
  input  logic          timer_done,
  input  logic [PW-1:0] power_level,
  output logic          mag_on,
  output logic          cooking,
  output logic          paused
);

  state_t state;
  state_t next_state;
  logic   start_q;
  logic   start_edge;
  logic   start_ok;
  logic   clear;
  logic   halt;
  logic   duty;

  assign start_edge = start_q && !startn;
  assign clear      = !clearn;
  assign halt       = !stopn || !door_closed;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) start_q <= 1'b1;
    else         start_q <= startn;
  end

`ifdef MAG_COOLDOWN_EN
  localparam int unsigned CW = $clog2(COOL_CYCLES + 1);

  logic [CW-1:0] cool_cnt;

  // Any COOK exit (including clear) re-arms the lockout.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cool_cnt <= '0;
    end else if (state == ST_COOK && next_state != ST_COOK) begin
      cool_cnt <= CW'(COOL_CYCLES);
    end else if (cool_cnt != '0) begin
      cool_cnt <= cool_cnt - CW'(1);
    end
  end

  assign start_ok = start_edge && (cool_cnt == '0);
`else
  if (COOL_CYCLES != 0) begin : g_cool_absent
  end

  assign start_ok = start_edge;
`endif

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE: begin
        if (!clear && !timer_done && !halt && start_ok) next_state = ST_COOK;
      end
      ST_COOK: begin
        if (clear || timer_done) next_state = ST_IDLE;
        else if (halt)           next_state = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (clear || timer_done)    next_state = ST_IDLE;
        else if (!halt && start_ok) next_state = ST_COOK;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= next_state;
  end

  mag_duty_gen #(
    .LEVELS (LEVELS),
    .SLICE  (SLICE)
  ) u_duty (
    .clk         (clk),
    .resetn      (resetn),
    .run         (next_state == ST_COOK),
    .restart     (state != ST_COOK),
    .power_level (power_level),
    .duty        (duty)
  );

  // Door interlock is combinational so an opening door kills RF the same cycle.
  assign mag_on  = duty && door_closed;
  assign cooking = (state == ST_COOK);
  assign paused  = (state == ST_PAUSE);

endmodule

// File: tb/tb_magnetron_duty_ctrl.sv
// Scoreboard bench for magnetron_duty_ctrl (LEVELS=10, SLICE=4, COOL_CYCLES=8);
// expected {mag_on, cooking, paused} per cycle are hand-derived directed vectors.
module tb_magnetron_duty_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic       startn;
  logic       stopn;
  logic       clearn;
  logic       door_closed;
  logic       timer_done;
  logic [3:0] power_level;
  logic       mag_on;
  logic       cooking;
  logic       paused;

  logic [2:0] exp_q[$];
  string      name_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  magnetron_duty_ctrl #(
    .LEVELS      (10),
    .SLICE       (4),
    .COOL_CYCLES (8)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .startn      (startn),
    .stopn       (stopn),
    .clearn      (clearn),
    .door_closed (door_closed),
    .timer_done  (timer_done),
    .power_level (power_level),
    .mag_on      (mag_on),
    .cooking     (cooking),
    .paused      (paused)
  );

  always #5 clk = ~clk;

  task automatic check(input int act, input int exp, input string nm);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Inputs are set just after a falling edge; the expectation describes the
  // outputs after the next rising edge, checked at the falling edge after it.
  task automatic tick(input logic [2:0] e, input string nm);
    @(posedge clk);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [2:0] e;
      string      nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      check(int'({mag_on, cooking, paused}), int'(e), nm);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  localparam logic [2:0] IDLE_E  = 3'b000;
  localparam logic [2:0] PAUSE_E = 3'b001;
  localparam logic [2:0] COOK0_E = 3'b010;
  localparam logic [2:0] COOK1_E = 3'b110;

  initial begin
    resetn      = 1'b0;
    startn      = 1'b1;
    stopn       = 1'b1;
    clearn      = 1'b1;
    door_closed = 1'b1;
    timer_done  = 1'b0;
    power_level = 4'd5;
    repeat (3) @(negedge clk);
    #1;
    check(int'({mag_on, cooking, paused}), 0, "reset_outputs");
    resetn = 1'b1;

    // Start refused with the door open.
    door_closed = 1'b0; startn = 1'b0;
    tick(IDLE_E, "start_door_open");
    door_closed = 1'b1; startn = 1'b1;
    tick(IDLE_E, "idle_door_closed");

    // Level 5: 20 on / 20 off per 40-cycle window, two full windows and more.
    startn = 1'b0;
    tick(COOK1_E, "start_l5");
    startn = 1'b1;
    for (int i = 1; i <= 92; i++)
      tick({((i % 40) < 20), 2'b10}, $sformatf("l5_win_%0d", i));

    // Door opens at window cycle 13: interlock drops mag_on before any edge.
    door_closed = 1'b0;
    #1;
    check(int'(mag_on), 0, "door_comb_mag");
    check(int'(cooking), 1, "door_comb_cook");
    tick(PAUSE_E, "door_open_pause");
    door_closed = 1'b1;
    for (int i = 0; i < 8; i++) tick(PAUSE_E, "pause_hold");
    startn = 1'b0;
    tick(COOK1_E, "resume");
    startn = 1'b1;
    for (int i = 1; i <= 20; i++)
      tick({(i < 20), 2'b10}, $sformatf("resume_win_%0d", i));

    // Stop, then clear from PAUSE.
    stopn = 1'b0;
    tick(PAUSE_E, "stop");
    stopn = 1'b1; clearn = 1'b0;
    tick(IDLE_E, "clear_pause");
    clearn = 1'b1;
    for (int i = 0; i < 8; i++) tick(IDLE_E, "idle_wait");

    // Level 0, then 10 (latched at the wrap), then 15 (clamped to 10).
    power_level = 4'd0; startn = 1'b0;
    tick(COOK0_E, "start_l0");
    startn = 1'b1;
    for (int i = 1; i <= 85; i++) begin
      if (i == 10) power_level = 4'd10;
      if (i == 50) power_level = 4'd15;
      tick({(i >= 40), 2'b10}, $sformatf("lvl_win_%0d", i));
    end

    // Clear from COOK; start coincident with timer_done is ignored.
    clearn = 1'b0;
    tick(IDLE_E, "clear_cook");
    clearn = 1'b1;
    for (int i = 0; i < 8; i++) tick(IDLE_E, "idle_wait2");
    startn = 1'b0; timer_done = 1'b1;
    tick(IDLE_E, "start_with_timer");
    timer_done = 1'b0;
    tick(IDLE_E, "held_start_no_edge");
    startn = 1'b1;
    tick(IDLE_E, "start_release");
    startn = 1'b0;
    tick(COOK1_E, "start_l15");
    startn = 1'b1;
    for (int i = 0; i < 3; i++) tick(COOK1_E, "l15_full");
    timer_done = 1'b1;
    tick(IDLE_E, "timer_cook");
    timer_done = 1'b0;
    for (int i = 0; i < 8; i++) tick(IDLE_E, "idle_wait3");

    // Stop, then start 3 cycles later and again 9 cycles later.
    startn = 1'b0;
    tick(COOK1_E, "start_cd");
    startn = 1'b1;
    tick(COOK1_E, "cook_cd");
    stopn = 1'b0;
    tick(PAUSE_E, "stop_cd");
    stopn = 1'b1;
    tick(PAUSE_E, "stop_cd_1");
    tick(PAUSE_E, "stop_cd_2");
    startn = 1'b0;
`ifdef MAG_COOLDOWN_EN
    tick(PAUSE_E, "start_in_cooldown");
    startn = 1'b1;
    for (int k = 4; k <= 8; k++) tick(PAUSE_E, $sformatf("cooldown_%0d", k));
`else
    tick(COOK1_E, "start_no_cooldown");
    startn = 1'b1;
    for (int k = 4; k <= 8; k++) tick(COOK1_E, $sformatf("no_cooldown_%0d", k));
`endif
    startn = 1'b0;
    tick(COOK1_E, "start_after_cooldown");
    startn = 1'b1;
    tick(COOK1_E, "cook_after_cooldown");

    // Asynchronous reset mid-window.
    resetn = 1'b0;
    #1;
    check(int'(mag_on), 0, "async_reset_mag");
    check(int'(cooking), 0, "async_reset_cook");
    check(int'(paused), 0, "async_reset_pause");
    tick(IDLE_E, "in_reset_1");
    tick(IDLE_E, "in_reset_2");
    resetn = 1'b1; power_level = 4'd5;
    for (int i = 0; i < 3; i++) tick(IDLE_E, "post_reset_idle");
    startn = 1'b0;
    tick(COOK1_E, "start_after_reset");
    startn = 1'b1;
    tick(COOK1_E, "cook_after_reset");

    @(negedge clk);
    #1;
    check(exp_q.size(), 0, "queue_drained");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
